// File: rtl/histogram_equalizer_lut_pkg.sv
// histogram_equalizer_lut_pkg
//   Shared constants, FSM state type and the normalise saturation helper
//   used by the histogram equalisation LUT builder.
package histogram_equalizer_lut_pkg;

    localparam int unsigned HIST_BINS = 256;
    localparam int unsigned PIXEL_W   = 8;
    // Widest normalised product the helper accepts (HIST_W + 8 must fit).
    localparam int unsigned NORM_W    = 64;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // Clamp a normalised CDF value to the pixel range.
    function automatic logic [PIXEL_W-1:0] sat_pixel(input logic [NORM_W-1:0] v);
        if (|v[NORM_W-1:PIXEL_W]) begin
            return '1;
        end
        return v[PIXEL_W-1:0];
    endfunction

endpackage

// File: rtl/histogram_equalizer_lut_lut_dp_ram.sv
// lut_dp_ram
//   256x8 simple dual-port RAM holding one equalisation LUT bank.
//   Ports:
//     clk      single clock for both ports
//     wr_en    write strobe, wr_addr/wr_data written at the clock edge
//     rd_addr  read address, rd_data valid the cycle after
//   Contents are not reset.
module lut_dp_ram
    import histogram_equalizer_lut_pkg::*;
(
    input  logic               clk,
    input  logic               wr_en,
    input  logic [PIXEL_W-1:0] wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic [PIXEL_W-1:0] rd_addr,
    output logic [PIXEL_W-1:0] rd_data
);

    logic [PIXEL_W-1:0] mem [HIST_BINS];
    logic [PIXEL_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/histogram_equalizer_lut.sv
// histogram_equalizer_lut
//   Reads a 256-bin histogram after a start pulse, accumulates the CDF,
//   turns it into a 256x8 equalisation LUT and remaps the live pixel stream
//   through it (1-cycle latency, identity until a LUT is available).
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     start                     build request (ignored while busy)
//     hist_addr/hist_rd_en      histogram read port, hist_data one cycle later
//     in_pixel/in_valid         input pixel stream
//     end_of_frame              frame marker (used only with double buffering)
//     out_pixel/out_valid       remapped pixel stream
//     busy, lut_ready, done     build status
//   Optional: define LUT_DOUBLE_BUFFER_EN for two LUT banks swapped on the
//   falling edge of end_of_frame so a frame never sees a mixed LUT.
module histogram_equalizer_lut
    import histogram_equalizer_lut_pkg::*;
#(
    parameter int unsigned PIX_SHIFT = 18,
    parameter int unsigned HIST_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [7:0]          hist_addr,
    output logic                hist_rd_en,
    input  logic [HIST_W-1:0]   hist_data,
    input  logic [7:0]          in_pixel,
    input  logic                in_valid,
    input  logic                end_of_frame,
    output logic [7:0]          out_pixel,
    output logic                out_valid,
    output logic                busy,
    output logic                lut_ready,
    output logic                done
);

    localparam logic [HIST_W+7:0] K255 = (HIST_W+8)'(255);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                rd_vld_q, rd_vld_d;
    logic [7:0]          rd_addr_q, rd_addr_d;
    logic                wr_vld_q, wr_vld_d;
    logic [7:0]          wr_addr_q, wr_addr_d;
    logic [HIST_W-1:0]   acc_q, acc_d;
    logic                lut_ready_q, lut_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [7:0]          ident_q, ident_d;
    logic                sel_q, sel_d;

    logic                start_ok;
    logic [HIST_W:0]     acc_sum;
    logic [HIST_W+7:0]   scaled;
    logic [7:0]          map_val;
    logic [7:0]          lut_data;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = READ;
            READ:    if (cnt_q == 8'(HIST_BINS - 1)) state_d = DRAIN;
            DRAIN:   if (cnt_q == 8'd1) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        hist_rd_en = 1'b0;
        hist_addr  = '0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_q)
            IDLE:    busy = 1'b0;
            READ: begin
                hist_rd_en = 1'b1;
                hist_addr  = cnt_q;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Build datapath ----------------
    // Stage 1: read issued (hist_rd_en). Stage 2: hist_data accumulated.
    // Stage 3: LUT written from the accumulator value of the previous stage.
    always_comb begin
        cnt_d     = (state_q == IDLE || state_d != state_q) ? '0 : cnt_q + 8'd1;
        rd_vld_d  = hist_rd_en;
        rd_addr_d = hist_addr;
        wr_vld_d  = rd_vld_q;
        wr_addr_d = rd_addr_q;

        acc_sum = {1'b0, acc_q} + {1'b0, hist_data};
        acc_d   = acc_q;
        if (start_ok) begin
            acc_d = '0;
        end else if (rd_vld_q) begin
            acc_d = acc_sum[HIST_W] ? '1 : acc_sum[HIST_W-1:0];
        end

        scaled  = ({8'd0, acc_q} * K255) >> PIX_SHIFT;
        map_val = sat_pixel(NORM_W'(scaled));

        out_valid_d = in_valid;
        ident_d     = in_pixel;
        sel_d       = lut_ready_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            rd_vld_q    <= 1'b0;
            rd_addr_q   <= '0;
            wr_vld_q    <= 1'b0;
            wr_addr_q   <= '0;
            acc_q       <= '0;
            lut_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            ident_q     <= '0;
            sel_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rd_vld_q    <= rd_vld_d;
            rd_addr_q   <= rd_addr_d;
            wr_vld_q    <= wr_vld_d;
            wr_addr_q   <= wr_addr_d;
            acc_q       <= acc_d;
            lut_ready_q <= lut_ready_d;
            out_valid_q <= out_valid_d;
            ident_q     <= ident_d;
            sel_q       <= sel_d;
        end
    end

`ifdef LUT_DOUBLE_BUFFER_EN
    // bank_q is the bank the pixel path reads; the build fills the other one.
    logic       bank_q, bank_d;
    logic       pending_q, pending_d;
    logic       eof_q, eof_d;
    logic       rd_bank_q, rd_bank_d;
    logic [7:0] rdata0, rdata1;

    always_comb begin
        start_ok    = start && (state_q == IDLE) && !pending_q;
        eof_d       = end_of_frame;
        rd_bank_d   = bank_q;
        bank_d      = bank_q;
        pending_d   = pending_q;
        lut_ready_d = lut_ready_q;
        if (state_q == DONE) begin
            pending_d = 1'b1;
        end else if (pending_q && eof_q && !end_of_frame) begin
            pending_d   = 1'b0;
            bank_d      = ~bank_q;
            lut_ready_d = 1'b1;
        end
        lut_data = rd_bank_q ? rdata1 : rdata0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q    <= 1'b0;
            pending_q <= 1'b0;
            eof_q     <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            pending_q <= pending_d;
            eof_q     <= eof_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    lut_dp_ram u_bank0 (
        .clk     (clk),
        .wr_en   (wr_vld_q && bank_q),
        .wr_addr (wr_addr_q),
        .wr_data (map_val),
        .rd_addr (in_pixel),
        .rd_data (rdata0)
    );

    lut_dp_ram u_bank1 (
        .clk     (clk),
        .wr_en   (wr_vld_q && !bank_q),
        .wr_addr (wr_addr_q),
        .wr_data (map_val),
        .rd_addr (in_pixel),
        .rd_data (rdata1)
    );
`else
    logic unused_eof;
    assign unused_eof = end_of_frame;

    always_comb begin
        start_ok    = start && (state_q == IDLE);
        lut_ready_d = lut_ready_q || (state_q == DONE);
    end

    lut_dp_ram u_bank0 (
        .clk     (clk),
        .wr_en   (wr_vld_q),
        .wr_addr (wr_addr_q),
        .wr_data (map_val),
        .rd_addr (in_pixel),
        .rd_data (lut_data)
    );
`endif

    assign out_pixel = sel_q ? lut_data : ident_q;
    assign out_valid = out_valid_q;
    assign lut_ready = lut_ready_q;

endmodule

// File: tb/tb_histogram_equalizer_lut.sv
module tb_histogram_equalizer_lut;

    localparam int unsigned PIX_SHIFT = 8;
    localparam int unsigned HIST_W    = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        hist_addr;
    logic              hist_rd_en;
    logic [HIST_W-1:0] hist_data = '0;
    logic [7:0]        in_pixel;
    logic              in_valid;
    logic              end_of_frame;
    logic [7:0]        out_pixel;
    logic              out_valid;
    logic              busy;
    logic              lut_ready;
    logic              done;

    always #5 clk = ~clk;

    histogram_equalizer_lut #(
        .PIX_SHIFT (PIX_SHIFT),
        .HIST_W    (HIST_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .hist_addr    (hist_addr),
        .hist_rd_en   (hist_rd_en),
        .hist_data    (hist_data),
        .in_pixel     (in_pixel),
        .in_valid     (in_valid),
        .end_of_frame (end_of_frame),
        .out_pixel    (out_pixel),
        .out_valid    (out_valid),
        .busy         (busy),
        .lut_ready    (lut_ready),
        .done         (done)
    );

    // Histogram memory with a synchronous read port.
    logic [HIST_W-1:0] hist_mem [256];
    always @(posedge clk) begin
        if (hist_rd_en) hist_data <= hist_mem[hist_addr];
    end

    int unsigned rd_count = 0;
    int unsigned done_count = 0;
    always @(posedge clk) begin
        if (hist_rd_en) rd_count <= rd_count + 1;
        if (done) done_count <= done_count + 1;
    end

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    logic [7:0] model_lut [256];

    typedef struct {
        logic [7:0] pix;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: running CDF clamped at 2^HIST_W-1, scaled by 255/2^PIX_SHIFT, clamped at 255.
    function automatic void build_model();
        longint unsigned cdf = 0;
        longint unsigned m;
        for (int k = 0; k < 256; k++) begin
            cdf = cdf + longint'(hist_mem[k]);
            if (cdf > 64'hFFFF_FFFF) cdf = 64'hFFFF_FFFF;
            m = (cdf * 255) >> PIX_SHIFT;
            model_lut[k] = (m > 255) ? 8'd255 : m[7:0];
        end
    endfunction

    task automatic apply_vecs(input string tag, input vec_t v[$]);
        foreach (v[i]) begin
            in_pixel = v[i].pix;
            in_valid = 1'b1;
            tick();
            check({tag, "_pix"}, out_pixel, v[i].exp);
            check({tag, "_vld"}, out_valid, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int p = 0; p < 256; p++) begin
            in_pixel = 8'(p);
            in_valid = 1'b1;
            tick();
            check(tag, out_pixel, model_lut[p]);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 400) begin
            tick();
            cyc++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic eof_pulse();
        end_of_frame = 1'b1;
        tick();
        end_of_frame = 1'b0;
        tick();
        tick();
    endtask

    task automatic run_build(input bit check_timing);
        int cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (check_timing) begin
            check("rd_en_cycle1", hist_rd_en, 1);
            check("addr_cycle1", hist_addr, 0);
            check("busy_cycle1", busy, 1);
        end
        wait_done(cyc);
        if (check_timing) check("done_cycle", cyc, 259);
        tick();
        check("done_pulse_len", done, 0);
        check("busy_after", busy, 0);
        eof_pulse();
        check("lut_ready", lut_ready, 1);
    endtask

    initial begin
        vec_t v[$];
        int cyc;
        int unsigned r0, d0;

        rst = 1'b1; start = 1'b0; in_pixel = '0; in_valid = 1'b0; end_of_frame = 1'b0;
        tick(); tick();
        check("rst_addr", hist_addr, 0);
        check("rst_rd_en", hist_rd_en, 0);
        check("rst_out_pixel", out_pixel, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_lut_ready", lut_ready, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // Identity before any build.
        v = '{'{8'd10, 8'd10}, '{8'd200, 8'd200}, '{8'd37, 8'd37}};
        apply_vecs("identity", v);
        check("identity_lut_ready", lut_ready, 0);
        tick();
        check("idle_out_valid", out_valid, 0);

        // Uniform histogram.
        for (int k = 0; k < 256; k++) hist_mem[k] = 1;
        build_model();
        run_build(1);
        v = '{'{8'd0, 8'd0}, '{8'd127, 8'd127}, '{8'd255, 8'd255}};
        apply_vecs("uniform", v);
        sweep("uniform_sweep");

        // Single populated bin.
        for (int k = 0; k < 256; k++) hist_mem[k] = 0;
        hist_mem[100] = 256;
        build_model();
        run_build(0);
        v = '{'{8'd99, 8'd0}, '{8'd100, 8'd255}, '{8'd0, 8'd0}, '{8'd255, 8'd255}};
        apply_vecs("single", v);
        sweep("single_sweep");

        // Accumulator saturation.
        for (int k = 0; k < 256; k++) hist_mem[k] = 0;
        hist_mem[0] = 32'hFFFF_FFFF;
        hist_mem[1] = 5;
        build_model();
        run_build(0);
        v = '{'{8'd1, 8'd255}, '{8'd2, 8'd255}, '{8'd255, 8'd255}};
        apply_vecs("saturate", v);
        sweep("saturate_sweep");

        // start re-asserted mid-build is ignored.
        for (int k = 0; k < 256; k++) hist_mem[k] = 1;
        build_model();
        r0 = rd_count; d0 = done_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 100; c++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
        for (int c = 0; c < 280; c++) tick();
        check("restart_reads", rd_count - r0, 256);
        check("restart_dones", done_count - d0, 1);
        eof_pulse();
        sweep("restart_sweep");

        // Randomised histograms.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 256; k++) begin
                hist_mem[k] = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 2);
            end
            build_model();
            run_build(0);
            sweep("random_sweep");
        end

`ifdef LUT_DOUBLE_BUFFER_EN
        // Build completes mid-frame: old mapping holds until end_of_frame falls.
        for (int k = 0; k < 256; k++) hist_mem[k] = 1;
        build_model();
        run_build(0);
        end_of_frame = 1'b1;
        for (int k = 0; k < 256; k++) hist_mem[k] = 0;
        hist_mem[100] = 256;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
        tick(); tick();
        v = '{'{8'd50, 8'd50}, '{8'd200, 8'd200}};
        apply_vecs("db_old", v);
        end_of_frame = 1'b0;
        tick(); tick();
        build_model();
        v = '{'{8'd50, 8'd0}, '{8'd200, 8'd255}};
        apply_vecs("db_new", v);
        sweep("db_sweep");
`endif

        // Reset in the middle of a build.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 50; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_rd_en", hist_rd_en, 0);
        check("abort_busy", busy, 0);
        check("abort_lut_ready", lut_ready, 0);
        check("abort_done", done, 0);
        v = '{'{8'd77, 8'd77}, '{8'd3, 8'd3}};
        apply_vecs("abort_identity", v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/histogram_equalizer_lut.md
Name: histogram_equalizer_lut

Overview:
Reader/consumer side of the histogram path. On a start pulse it reads the 256-bin histogram through a synchronous read port and accumulates the CDF. From the CDF it builds a 256x8 equalization LUT, then remaps the live 8-bit pixel stream through that LUT. It sits downstream of the histogram calculator, which drives start from its out_valid, and upstream of the 2D FIR pixel pipeline.

Parameters:
PIX_SHIFT, 18, log2 of pixels per frame; the CDF is normalised by right shift.
HIST_W, 32, histogram bin and CDF accumulator width.

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
start  in  1  build request, sampled high for one cycle
hist_addr  out  8  histogram bin read address
hist_rd_en  out  1  histogram read enable
hist_data  in  HIST_W  bin value, valid the cycle after hist_rd_en
in_pixel  in  8  input pixel
in_valid  in  1  input pixel qualifier
end_of_frame  in  1  frame marker from pixel source, level
out_pixel  out  8  remapped pixel
out_valid  out  1  out_pixel qualifier
busy  out  1  high while a build is in progress
lut_ready  out  1  high once at least one LUT build has completed
done  out  1  one-cycle pulse when a build finishes

Behaviour:
- Reset values: hist_addr=0, hist_rd_en=0, out_pixel=0, out_valid=0, busy=0, lut_ready=0, done=0. State returns to IDLE and the accumulator clears to 0. LUT RAM contents are not cleared (undefined).
- FSM states and transitions:
  - IDLE: on start, go to READ.
  - READ: lasts 256 cycles. hist_rd_en=1 and hist_addr=0..255, one per cycle.
  - DRAIN: lasts 2 cycles to flush the pipeline.
  - DONE: lasts 1 cycle, asserts done, sets lut_ready, returns to IDLE.
- busy=1 in READ, DRAIN and DONE.
- Timing, with start sampled at edge 0:
  - Address k is issued in cycle k+1; hist_data for bin k is valid in cycle k+2.
  - Accumulator acc <= acc + hist_data at the end of cycle k+2, giving cdf[k].
  - LUT[k] is written at the end of cycle k+3.
  - done is high in cycle 259.
- Arithmetic:
  - acc saturates at 2^HIST_W-1; it never wraps.
  - map = (acc * 255) >> PIX_SHIFT, computed at HIST_W+8 bits, then saturated to 255.
- Pixel path: 1-cycle latency. out_valid <= in_valid; out_pixel <= LUT[in_pixel].
  - While lut_ready=0, out_pixel <= in_pixel (identity).
  - The pixel read port is independent of the build write port (dual-port RAM).
  - In the base build, pixels arriving during a build may see a mix of old and new entries.
- start while busy=1 is ignored, with no queuing.
- rst mid-build aborts the build; lut_ready returns to 0, so identity mapping applies until the next complete build.
- end_of_frame is unused unless the optional feature is enabled.

Optional Feature:
- Macro LUT_DOUBLE_BUFFER_EN.
- Defined:
  - Two LUT banks. The build writes the shadow bank; pixels read the active bank.
  - After done, a pending-swap flag is set. Banks swap on the falling edge of end_of_frame, so a frame is never mixed.
  - lut_ready rises at the first swap, not at done.
  - A new start while a swap is pending is ignored.
- Undefined: single bank with the mixed-frame behaviour above.

Decomposition:
- Shared package holds:
  - HIST_BINS=256 and PIXEL_W=8 constants.
  - State typedef: IDLE, READ, DRAIN, DONE.
  - Saturation helper for the normalise step.
- Sub-module lut_dp_ram: 256x8, one synchronous write port, one synchronous read port, same clk. Instantiated twice under LUT_DOUBLE_BUFFER_EN.

Test Plan:
- Uniform histogram, PIX_SHIFT=8, every bin=1, start pulse -> done in cycle 259; LUT[0]=0, LUT[127]=127, LUT[255]=255; in_pixel=127 gives out_pixel=127 one cycle later.
- Single-bin histogram, PIX_SHIFT=8, bin 100=256 and all others 0 -> LUT[0..99]=0, LUT[100..255]=255; in_pixel=99 gives 0, in_pixel=100 gives 255.
- Saturation: bin 0=2^32-1 and bin 1=5 -> acc holds 2^32-1 and LUT[1..255]=255, with no wrap.
- Before first build: stream 10,200,37 with in_valid=1 -> out 10,200,37 with 1-cycle latency; lut_ready=0.
- start re-asserted at cycle 100 of a build -> ignored; exactly 256 reads occur and one done pulse. rst at cycle 50 -> hist_rd_en=0 next cycle, lut_ready=0, busy=0.
- LUT_DOUBLE_BUFFER_EN: build completes mid-frame -> outputs keep the old mapping until end_of_frame falls, then switch to the new mapping.
